// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient/sample sequencer.
package fir_pkg;

    localparam int unsigned DefDataWidth = 12;
    localparam int unsigned DefNTaps     = 9;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStart,
        StBusy
    } state_e;

    // Symmetric odd-length filter: only half the taps (plus centre) are stored.
    function automatic int unsigned n_coeffs(input int unsigned n_taps);
        return (n_taps + 1) / 2;
    endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Handshake and FIR-control bundle around the sequencer.
interface fir_sequencer_if
    import fir_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [DataWidth-1:0] cfg_data;
    logic                 cfg_sym;
    logic                 s_valid;
    logic                 s_ready;
    logic [DataWidth-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [DataWidth-1:0] m_data;
    logic                 fir_start;
    logic                 fir_lock;
    logic                 fir_coeff_load;
    logic                 fir_coeff_bit;
    logic                 fir_sym;
    logic [DataWidth-1:0] fir_x;
    logic                 fir_done;
    logic [DataWidth-1:0] fir_y;
    logic                 err;
    logic                 err_clr;

    // Environment side: upstream/downstream and the FIR core.
    modport master (
        output cfg_valid, cfg_data, cfg_sym, s_valid, s_data, m_ready, fir_done, fir_y, err_clr,
        input  cfg_ready, s_ready, m_valid, m_data, fir_start, fir_lock, fir_coeff_load,
               fir_coeff_bit, fir_sym, fir_x, err
    );

    // Sequencer side.
    modport slave (
        input  cfg_valid, cfg_data, cfg_sym, s_valid, s_data, m_ready, fir_done, fir_y, err_clr,
        output cfg_ready, s_ready, m_valid, m_data, fir_start, fir_lock, fir_coeff_load,
               fir_coeff_bit, fir_sym, fir_x, err
    );
endinterface

// File: rtl/fir_coeff_ser.sv
// Coefficient word serializer: MSB goes out on the accept cycle, the remaining
// bits follow one per cycle so back-to-back words form a gapless bit stream.
module fir_coeff_ser
    import fir_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 empty_o,
    output logic                 last_o,
    output logic                 active_o,
    output logic                 bit_o
);
    localparam int unsigned CntW = $clog2(DataWidth);

    logic [DataWidth-2:0] shift_q;
    logic [CntW-1:0]      cnt_q;

    // Output bit comes straight from the word on the accept cycle, else from the shifter.
    always_comb begin
        empty_o  = (cnt_q == '0);
        last_o   = (cnt_q == CntW'(1));
        active_o = load_i || !empty_o;
        bit_o    = load_i ? data_i[DataWidth-1] : (!empty_o && shift_q[DataWidth-2]);
    end

    // Shift register and remaining-bit counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shift_q <= data_i[DataWidth-2:0];
            cnt_q   <= CntW'(DataWidth - 1);
        end else if (!empty_o) begin
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q - CntW'(1);
        end
    end
endmodule

// File: rtl/fir_sequencer.sv
// Sequences coefficient loads and sample runs into a bit-serial FIR core,
// with a BUSY watchdog and a single-entry output register.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned DataWidth     = DefDataWidth,
    parameter int unsigned NTaps         = DefNTaps,
    parameter int unsigned NCoeffs       = n_coeffs(NTaps),
    parameter int unsigned TimeoutCycles = 2 * NCoeffs * DataWidth
) (
    input logic            clk,
    input logic            rstN,
    fir_sequencer_if.slave bus
);
    localparam int unsigned WcntW = $clog2(NCoeffs + 1);
    localparam int unsigned WdogW = $clog2(TimeoutCycles + 1);

    state_e               state_q, state_d;
    logic [WcntW-1:0]     wcnt_q, wcnt_d;
    logic [WdogW-1:0]     wdog_q, wdog_d;
    logic [DataWidth-1:0] fir_x_q, fir_x_d;
    logic [DataWidth-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 fir_sym_q, fir_sym_d;
    logic                 err_q, err_d;
    logic                 live_q;
    logic                 cfg_ready, s_ready, cfg_acc, s_acc, timeout;
    logic                 ser_empty, ser_last, ser_active, ser_bit;

    fir_coeff_ser #(
        .DataWidth(DataWidth)
    ) u_ser (
        .clk     (clk),
        .rstN    (rstN),
        .load_i  (cfg_acc),
        .data_i  (bus.cfg_data),
        .empty_o (ser_empty),
        .last_o  (ser_last),
        .active_o(ser_active),
        .bit_o   (ser_bit)
    );

    // Handshake readiness; live_q keeps both readies low during and just after reset.
    always_comb begin
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        if (live_q) begin
            cfg_ready = ser_empty && ((state_q == StIdle) ||
                                      (state_q == StLoad && wcnt_q < WcntW'(NCoeffs)));
            s_ready   = (state_q == StIdle) && !bus.cfg_valid && (!m_valid_q || bus.m_ready);
        end
        cfg_acc = bus.cfg_valid && cfg_ready;
        s_acc   = bus.s_valid && s_ready;
        timeout = (state_q == StBusy) && !bus.fir_done && (wdog_q == WdogW'(TimeoutCycles - 1));
    end

    // Next-state, watchdog and datapath registers.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        wdog_d    = '0;
        fir_x_d   = fir_x_q;
        fir_sym_d = fir_sym_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        err_d     = err_q;
        if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_acc) begin
                    state_d   = StLoad;
                    wcnt_d    = WcntW'(1);
                    fir_sym_d = bus.cfg_sym;
                end else if (s_acc) begin
                    state_d = StStart;
                    fir_x_d = bus.s_data;
                end
            end
            StLoad: begin
                if (cfg_acc) wcnt_d = wcnt_q + WcntW'(1);
                if (wcnt_q == WcntW'(NCoeffs) && ser_last) begin
                    state_d = StIdle;
                    wcnt_d  = '0;
                end
            end
            StStart: state_d = StBusy;
            StBusy: begin
                wdog_d = wdog_q + WdogW'(1);
                if (bus.fir_done) begin
                    state_d   = StIdle;
                    m_data_d  = bus.fir_y;
                    m_valid_d = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A timeout wins over a simultaneous clear.
        if (timeout) err_d = 1'b1;
        else if (bus.err_clr) err_d = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= StIdle;
            wcnt_q    <= '0;
            wdog_q    <= '0;
            fir_x_q   <= '0;
            fir_sym_q <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            wdog_q    <= wdog_d;
            fir_x_q   <= fir_x_d;
            fir_sym_q <= fir_sym_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            live_q    <= 1'b1;
        end
    end

    assign bus.cfg_ready      = cfg_ready;
    assign bus.s_ready        = s_ready;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_data         = m_data_q;
    assign bus.fir_start      = (state_q == StStart);
    assign bus.fir_lock       = (state_q != StBusy);
    assign bus.fir_coeff_load = ser_active;
    assign bus.fir_coeff_bit  = ser_active && ser_bit;
    assign bus.fir_sym        = fir_sym_q;
    assign bus.fir_x          = fir_x_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a simple fixed-latency FIR core model.
module tb_fir_sequencer;
    import fir_pkg::*;

    logic        clk;
    logic        rstN;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        fir_en = 1'b1;
    logic        force_done = 1'b0;
    int          fcnt = 0;
    logic [11:0] cw [5];

    localparam logic [59:0] ExpBits = 60'h400200100080040;
    // {s_ready,cfg_ready,m_valid,fir_start,fir_lock,fir_coeff_load,fir_coeff_bit,fir_sym,err}
    localparam logic [8:0]  RstCtl  = 9'b000010000;

    fir_sequencer_if #(.DataWidth(12)) bus ();

    fir_sequencer #(
        .DataWidth(12),
        .NTaps    (9)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIR core model: fir_done 61 cycles after the fir_start cycle.
    always @(posedge clk) begin
        #2;
        if (bus.fir_start) fcnt = 1;
        else if (fcnt != 0) fcnt = fcnt + 1;
        bus.fir_done = (fir_en && fcnt == 62) || force_done;
        if (fcnt == 62) fcnt = 0;
    end

    function automatic logic [8:0] ctl_vec();
        return {bus.s_ready, bus.cfg_ready, bus.m_valid, bus.fir_start, bus.fir_lock,
                bus.fir_coeff_load, bus.fir_coeff_bit, bus.fir_sym, bus.err};
    endfunction

    // Drives a 5-word load from cw[]; optional 15-cycle cfg_valid gap after word gap_after.
    task automatic do_load(input logic sym, input int gap_after, output int n_load,
                           output logic [59:0] bits, output int span, output int idle_ld,
                           output int srdy_hits, output logic init_srdy, output logic init_crdy,
                           output logic done);
        int idx, gap, cyc, first, last;
        logic acc;
        idx = 0; gap = 0; cyc = 0; first = -1; last = -1; n_load = 0; bits = '0;
        idle_ld = 0; srdy_hits = 0; done = 1'b0; init_srdy = 1'b0; init_crdy = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_data = cw[0]; bus.cfg_sym = sym;
        while (cyc < 300 && !done) begin
            @(negedge clk);
            if (cyc == 0) begin init_srdy = bus.s_ready; init_crdy = bus.cfg_ready; end
            if (bus.fir_coeff_load) begin
                if (n_load < 60) bits[59-n_load] = bus.fir_coeff_bit;
                n_load++;
                if (first < 0) first = cyc;
                last = cyc;
                if (bus.s_ready) srdy_hits++;
            end else if (dut.state_q == StLoad) begin
                idle_ld++;
            end else if (idx == 5) begin
                done = 1'b1;
            end
            if (!done) begin
                acc = bus.cfg_valid && bus.cfg_ready;
                @(posedge clk); #1; cyc++;
                if (acc) begin
                    idx++;
                    bus.cfg_sym = !sym;
                    if (idx == 5) bus.cfg_valid = 1'b0;
                    else begin
                        bus.cfg_data = cw[idx];
                        if (idx == gap_after + 1) begin bus.cfg_valid = 1'b0; gap = 15; end
                    end
                end else if (gap > 0) begin
                    gap--;
                    if (gap == 0) bus.cfg_valid = 1'b1;
                end
            end
        end
        span = last - first + 1;
        bus.cfg_valid = 1'b0;
    endtask

    // Waits (bounded) for m_valid; returns posedges taken.
    task automatic wait_mvalid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            bus.s_valid = 1'b0;
            @(negedge clk);
        end while (!bus.m_valid && n < 200);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ctl_vec() !== RstCtl) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl_vec(), RstCtl);
        end
        n_checks++;
        if (bus.fir_x !== 12'h000) begin
            n_fail++; $display("FAIL reset_fir_x: got %h expected 000", bus.fir_x);
        end
        n_checks++;
        if (bus.m_data !== 12'h000) begin
            n_fail++; $display("FAIL reset_m_data: got %h expected 000", bus.m_data);
        end
        @(posedge clk); #1; rstN = 1'b1;
    endtask

    task automatic test_load(input string tag, input logic sym, input int gap_after,
                             input int exp_idle);
        int nl, sp, il, sh;
        logic [59:0] b;
        logic ir, ic, dn;
        do_load(sym, gap_after, nl, b, sp, il, sh, ir, ic, dn);
        n_checks++;
        if (dn !== 1'b1) begin n_fail++; $display("FAIL %s_done: load never completed", tag); end
        n_checks++;
        if (nl != 60) begin n_fail++; $display("FAIL %s_cycles: got %0d expected 60", tag, nl); end
        n_checks++;
        if (b !== ExpBits) begin
            n_fail++; $display("FAIL %s_bits: got %h expected %h", tag, b, ExpBits);
        end
        n_checks++;
        if (il != exp_idle) begin
            n_fail++; $display("FAIL %s_idle_in_load: got %0d expected %0d", tag, il, exp_idle);
        end
        n_checks++;
        if (gap_after < 0 && sp != 60) begin
            n_fail++; $display("FAIL %s_contig: span %0d expected 60", tag, sp);
        end
        n_checks++;
        if (bus.fir_sym !== sym) begin
            n_fail++; $display("FAIL %s_sym: got %b expected %b", tag, bus.fir_sym, sym);
        end
        n_checks++;
        if (dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL %s_state: got %0d expected IDLE", tag, dut.state_q);
        end
    endtask

    task automatic test_sample();
        int n, starts, busy;
        starts = 0; busy = 0; n = 0;
        @(posedge clk); #1;
        bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = 12'h100; bus.fir_y = 12'h2A5;
        @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL sample_accept: s_ready 0"); end
        do begin
            @(posedge clk); #1; n++;
            bus.s_valid = 1'b0;
            @(negedge clk);
            if (bus.fir_start) starts++;
            if (!bus.fir_lock) busy++;
        end while (!bus.m_valid && n < 200);
        n_checks++;
        if (n != 63) begin n_fail++; $display("FAIL sample_latency: got %0d expected 63", n); end
        n_checks++;
        if (starts != 1) begin n_fail++; $display("FAIL sample_start: got %0d pulses expected 1", starts); end
        n_checks++;
        if (busy != 61) begin n_fail++; $display("FAIL sample_lock: got %0d unlocked expected 61", busy); end
        n_checks++;
        if (bus.m_data !== 12'h2A5) begin
            n_fail++; $display("FAIL sample_m_data: got %h expected 2a5", bus.m_data);
        end
        n_checks++;
        if (bus.fir_x !== 12'h100) begin
            n_fail++; $display("FAIL sample_fir_x: got %h expected 100", bus.fir_x);
        end
    endtask

    task automatic test_back_to_back();
        int bad_rdy, bad_data, n;
        bad_rdy = 0; bad_data = 0;
        @(posedge clk); #1;
        bus.s_valid = 1'b1; bus.s_data = 12'h0AB; bus.fir_y = 12'h155;
        repeat (5) begin
            @(negedge clk);
            if (bus.s_ready) bad_rdy++;
            if (bus.m_data !== 12'h2A5 || !bus.m_valid) bad_data++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad_rdy != 0) begin n_fail++; $display("FAIL bp_s_ready: high %0d cycles expected 0", bad_rdy); end
        n_checks++;
        if (bad_data != 0) begin n_fail++; $display("FAIL bp_hold: output changed %0d cycles expected 0", bad_data); end
        bus.m_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: s_ready 0 expected 1"); end
        @(posedge clk); #1; bus.m_ready = 1'b0; bus.s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: m_valid 1 expected 0"); end
        wait_mvalid(n);
        n_checks++;
        if (bus.m_data !== 12'h155 || bus.fir_x !== 12'h0AB) begin
            n_fail++; $display("FAIL bp_second: got m_data %h fir_x %h expected 155 0ab", bus.m_data, bus.fir_x);
        end
        @(posedge clk); #1; bus.m_ready = 1'b1;
        @(posedge clk); #1; bus.m_ready = 1'b0;
    endtask

    task automatic test_priority();
        int nl, sp, il, sh, n;
        logic [59:0] b;
        logic ir, ic, dn;
        @(posedge clk); #1;
        bus.s_valid = 1'b1; bus.s_data = 12'h033; bus.fir_y = 12'h0F0;
        do_load(1'b0, -1, nl, b, sp, il, sh, ir, ic, dn);
        n_checks++;
        if (ir !== 1'b0 || ic !== 1'b1) begin
            n_fail++; $display("FAIL prio_first: s_ready %b cfg_ready %b expected 0 1", ir, ic);
        end
        n_checks++;
        if (sh != 0 || nl != 60) begin
            n_fail++; $display("FAIL prio_load: s_ready hits %0d loads %0d expected 0 60", sh, nl);
        end
        n_checks++;
        if (bus.fir_sym !== 1'b0) begin n_fail++; $display("FAIL prio_sym: got %b expected 0", bus.fir_sym); end
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL prio_after: s_ready 0 expected 1"); end
        @(posedge clk); #1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        wait_mvalid(n);
        n_checks++;
        if (bus.m_data !== 12'h0F0 || bus.fir_x !== 12'h033) begin
            n_fail++; $display("FAIL prio_result: got m_data %h fir_x %h expected 0f0 033", bus.m_data, bus.fir_x);
        end
        @(posedge clk); #1; bus.m_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int busy, mv, n;
        logic seen_busy;
        // Stray fir_done in IDLE must not produce output.
        @(posedge clk); #1; force_done = 1'b1;
        @(posedge clk); #1; force_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stray_done: m_valid 1 expected 0"); end
        fir_en = 1'b0; busy = 0; mv = 0; n = 0;
        @(posedge clk); #1; bus.s_valid = 1'b1; bus.s_data = 12'h7FF;
        do begin
            @(posedge clk); #1; n++; bus.s_valid = 1'b0;
            @(negedge clk);
            if (!bus.fir_lock) busy++;
            if (bus.m_valid) mv++;
        end while (!bus.err && n < 300);
        n_checks++;
        if (busy != 120) begin n_fail++; $display("FAIL wdog_cycles: got %0d busy cycles expected 120", busy); end
        n_checks++;
        if (mv != 0 || dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL wdog_abort: m_valid cycles %0d state %0d expected 0 IDLE", mv, dut.state_q);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got 0 expected 1"); end
        @(posedge clk); #1; bus.err_clr = 1'b1;
        @(posedge clk); #1; bus.err_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got 1 expected 0"); end
        // Second timeout with err_clr held: the timeout cycle must still set err.
        @(posedge clk); #1; bus.err_clr = 1'b1; bus.s_valid = 1'b1; bus.s_data = 12'h001;
        seen_busy = 1'b0; n = 0;
        do begin
            @(posedge clk); #1; n++; bus.s_valid = 1'b0;
            @(negedge clk);
            if (!bus.fir_lock) seen_busy = 1'b1;
        end while (!(seen_busy && bus.fir_lock) && n < 300);
        n_checks++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_clr_vs_timeout: got 0 expected 1"); end
        @(negedge clk);
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clr_after: got 1 expected 0"); end
        @(posedge clk); #1; bus.err_clr = 1'b0; fir_en = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        int idx, nl, cyc;
        logic acc;
        idx = 0; nl = 0; cyc = 0;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b1; bus.cfg_data = cw[0]; bus.cfg_sym = 1'b1;
        while (nl < 30 && cyc < 200) begin
            @(negedge clk);
            if (bus.fir_coeff_load) nl++;
            acc = bus.cfg_valid && bus.cfg_ready;
            if (nl < 30) begin
                @(posedge clk); #1; cyc++;
                if (acc) begin idx++; bus.cfg_data = cw[idx]; end
            end
        end
        n_checks++;
        if (bus.fir_sym !== 1'b1 || nl != 30) begin
            n_fail++; $display("FAIL midrst_pre: fir_sym %b bits %0d expected 1 30", bus.fir_sym, nl);
        end
        #1; rstN = 1'b0; bus.cfg_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl_vec() !== RstCtl || dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL midrst_ctl: got %b expected %b", ctl_vec(), RstCtl);
        end
        n_checks++;
        if (bus.m_data !== 12'h000 || bus.fir_x !== 12'h000) begin
            n_fail++; $display("FAIL midrst_data: got m_data %h fir_x %h expected 000 000", bus.m_data, bus.fir_x);
        end
        @(posedge clk); #1; rstN = 1'b1;
        test_load("reload_gap", 1'b1, 1, 4);
    endtask

    initial begin
        cw[0] = 12'h400; cw[1] = 12'h200; cw[2] = 12'h100; cw[3] = 12'h080; cw[4] = 12'h040;
        rstN = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_sym = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        bus.fir_done = 1'b0; bus.fir_y = '0; bus.err_clr = 1'b0;
        test_reset();
        test_load("load", 1'b1, -1, 0);
        test_sample();
        test_back_to_back();
        test_priority();
        test_timeout();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
